palette_packer: RTL and testbench
=================================

PALETTE_PACKER -- requirements
Module: palette_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit write words buffered; power of two, 2..16.
REQ-002 Parameter ADDR_W, default 24, byte address width of the slave and master ports.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 avs_slave_write  in  1  Avalon-MM write request carrying two RGB565 pixels.
REQ-006 avs_slave_address  in  ADDR_W  destination byte address.
REQ-007 avs_slave_writedata  in  32  pixel A in [31:16], pixel B in [15:0].
REQ-008 avs_slave_waitrequest  out  1  high when the FIFO is full.
REQ-009 avm_master_write  out  1  Avalon-MM byte write request.
REQ-010 avm_master_address  out  ADDR_W  byte address, passed through unchanged.
REQ-011 avm_master_writedata  out  8  {index(A), index(B)}, with A in the high nibble.
REQ-012 avm_master_waitrequest  in  1  downstream stall.
REQ-013 avs_palette_address  in  4  palette entry select.
REQ-014 avs_palette_writedata  in  16  RGB565 entry value.
REQ-015 avs_palette_write  in  1  palette entry write strobe.
REQ-016 avs_palette_readdata  out  16  entry at avs_palette_address, registered, one-cycle latency.
REQ-017 lookup_miss  out  1  sticky flag: some pixel had no exact palette match.

Function
REQ-018 Accept: a slave write is accepted on an edge where avs_slave_write=1 and avs_slave_waitrequest=0; the {address, data} pair is pushed to the FIFO.
REQ-019 avs_slave_waitrequest shall be the registered FIFO-full state; with FIFO_DEPTH entries held it stays 1 until a pop occurs.
REQ-020 Simultaneous push and pop when full: the pop frees a slot; waitrequest drops on the following cycle. No data loss or duplication.
REQ-021 Lookup stage: when the lookup register is empty, or is being drained this cycle, pop the FIFO head and register the address and both 4-bit indices.
REQ-022 Exact match: the index is the lowest palette entry equal to the pixel.
REQ-023 Palette contents sampled in the pop cycle apply; a same-cycle palette write is not seen by that pixel.
REQ-024 Output stage: avm_master_write is held with constant address and data until an edge where avm_master_waitrequest=0; the next packed byte may follow back-to-back.
REQ-025 Latency: a write accepted at edge N into an idle block drives avm_master_write=1 from edge N+2.
REQ-026 Byte order is strictly first-in, first-out; no writes are dropped or merged.
REQ-027 Palette port: a write updates the entry at the edge; the same-cycle readdata returns the old value.

Reset
REQ-028 Reset clears the FIFO, the lookup register and the output register.
REQ-029 Reset drives all outputs to 0: avm_master_write, avm_master_address, avm_master_writedata, avs_slave_waitrequest, avs_palette_readdata and lookup_miss.
REQ-030 Reset restores the palette to black, white, red, green, blue, cyan, magenta, yellow, repeated across entries 8-15.
REQ-031 Reset mid-transfer abandons any in-flight master write; the write is not reissued.

Configuration
REQ-032 Macro PALETTE_PACKER_NEAREST_EN is defined: an unmatched pixel maps to the entry with minimum |dR|+|dG|+|dB| over the raw 5/6/5 fields; ties go to the lowest index. lookup_miss still sets.
REQ-033 Macro PALETTE_PACKER_NEAREST_EN is undefined: an unmatched pixel maps to index 0 and sets lookup_miss.

Structure
REQ-034 The shared package palette_pkg shall hold:
- the rgb565_t typedef;
- the PIXEL16/PIXEL24 packing functions;
- the default palette constant;
- the PALETTE_ENTRIES=16 constant.
REQ-035 Sub-module palette_match shall be combinational: 16 entries + 1 pixel -> 4-bit index + miss. It is instantiated twice, once for pixel A and once for pixel B.

Verification
REQ-036 Reset then write addr 0x000010 data 0xFFFF_F800 -> exactly one master write at edge N+2, addr 0x000010, data 0x12.
REQ-037 Hold avm_master_waitrequest=1 and push 5 words with FIFO_DEPTH=4:
- slave waitrequest rises once 4 entries are held plus 1 in lookup/output;
- after release, bytes emerge in order with no loss.
REQ-038 Write palette[9]=0x1234, then pixel pair 0x1234_0000 -> data 0x90; a readback of palette[9] returns 0x1234.
REQ-039 Pixel 0x0841 with NEAREST_EN undefined -> nibble 0 and lookup_miss=1.
REQ-040 Pixel 0x0841 with NEAREST_EN defined -> nibble 0 (nearest entry is black) and lookup_miss=1.
REQ-041 Assert reset while a master write is stalled -> avm_master_write=0 on the next cycle, and a post-reset palette read of entry 2 returns 0xF800.

Source files
------------

// File: rtl/palette_pkg.sv
// palette_pkg: RGB565 pixel type, packing helpers and the 16-entry reset palette
// shared by palette_packer and palette_match.
package palette_pkg;

  localparam int PALETTE_ENTRIES = 16;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Entry 0 sits at the least-significant end: black, white, red, green,
  // blue, cyan, magenta, yellow, then the same eight again for 8-15.
  localparam rgb565_t [PALETTE_ENTRIES-1:0] DEFAULT_PALETTE = {
    2{16'hFFE0, 16'hF81F, 16'h07FF, 16'h001F,
      16'h07E0, 16'hF800, 16'hFFFF, 16'h0000}
  };

  function automatic rgb565_t PIXEL16(input logic [4:0] r,
                                      input logic [5:0] g,
                                      input logic [4:0] b);
    rgb565_t p;
    p.r = r;
    p.g = g;
    p.b = b;
    return p;
  endfunction

  // Rounded rescale so that 8'hFF reaches full scale in every field.
  function automatic rgb565_t PIXEL24(input logic [7:0] r,
                                      input logic [7:0] g,
                                      input logic [7:0] b);
    logic [12:0] rs;
    logic [13:0] gs;
    logic [12:0] bs;
    rs = 13'(r) * 13'd31 + 13'd127;
    gs = 14'(g) * 14'd63 + 14'd127;
    bs = 13'(b) * 13'd31 + 13'd127;
    return PIXEL16(5'(rs / 13'd255), 6'(gs / 14'd255), 5'(bs / 13'd255));
  endfunction

  function automatic logic [7:0] l1_dist(input rgb565_t a, input rgb565_t b);
    logic [7:0] dr;
    logic [7:0] dg;
    logic [7:0] db;
    dr = (a.r > b.r) ? 8'(a.r - b.r) : 8'(b.r - a.r);
    dg = (a.g > b.g) ? 8'(a.g - b.g) : 8'(b.g - a.g);
    db = (a.b > b.b) ? 8'(a.b - b.b) : 8'(b.b - a.b);
    return dr + dg + db;
  endfunction

endpackage

// File: rtl/palette_match.sv
// palette_match: combinational pixel-to-index lookup over the 16-entry palette.
// Define PALETTE_PACKER_NEAREST_EN to map misses to the L1-nearest entry
// instead of entry 0.
module palette_match
  import palette_pkg::*;
(
  input  rgb565_t [PALETTE_ENTRIES-1:0] palette,
  input  rgb565_t                       pixel,
  output logic [3:0]                    index,
  output logic                          miss
);

`ifdef PALETTE_PACKER_NEAREST_EN
  logic [7:0] best_dist;
  logic [7:0] dist;
`endif

  always_comb begin
    // NOTE: every output gets a value before any branch, so no path can leave
    // it unassigned and infer a latch.
    index = '0;
    miss  = 1'b1;
`ifdef PALETTE_PACKER_NEAREST_EN
    best_dist = '1;
    dist      = '0;
`endif
    // Scan downward so the lowest matching entry is the one left standing.
    for (int i = PALETTE_ENTRIES - 1; i >= 0; i--) begin
      if (palette[i] == pixel) begin
        index = 4'(i);
        miss  = 1'b0;
      end
    end
`ifdef PALETTE_PACKER_NEAREST_EN
    if (miss) begin
      // Strict less-than keeps the lowest index on ties.
      for (int i = 0; i < PALETTE_ENTRIES; i++) begin
        dist = l1_dist(palette[i], pixel);
        if (dist < best_dist) begin
          best_dist = dist;
          index     = 4'(i);
        end
      end
    end
`endif
  end

endmodule

// File: rtl/palette_packer.sv
// palette_packer: buffers 32-bit two-pixel RGB565 writes, maps each pixel to a
// 4-bit palette index and emits one packed byte write per word.
// Optional macro PALETTE_PACKER_NEAREST_EN selects nearest-colour mapping on a miss.
module palette_packer
  import palette_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 24
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              avs_slave_write,
  input  logic [ADDR_W-1:0] avs_slave_address,
  input  logic [31:0]       avs_slave_writedata,
  output logic              avs_slave_waitrequest,

  output logic              avm_master_write,
  output logic [ADDR_W-1:0] avm_master_address,
  output logic [7:0]        avm_master_writedata,
  input  logic              avm_master_waitrequest,

  input  logic [3:0]        avs_palette_address,
  input  logic [15:0]       avs_palette_writedata,
  input  logic              avs_palette_write,
  output logic [15:0]       avs_palette_readdata,

  output logic              lookup_miss
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              full_q;

  logic              push;
  logic              pop;
  logic              drain;

  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       head_data;
  rgb565_t           pix_a;
  rgb565_t           pix_b;
  logic [3:0]        idx_a;
  logic [3:0]        idx_b;
  logic              miss_a;
  logic              miss_b;

  rgb565_t [PALETTE_ENTRIES-1:0] palette_q;
  logic [15:0]       readdata_q;

  // The lookup register is also the master-port holding register.
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        out_data;
  logic              miss_q;

  assign push  = avs_slave_write && !full_q;
  assign drain = out_valid && !avm_master_waitrequest;
  assign pop   = (count != '0) && (!out_valid || drain);

  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every block sees
    // the pre-edge values regardless of evaluation order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      full_q <= (count_next == CNT_W'(FIFO_DEPTH));
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers and count
  // define which slots are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= avs_slave_address;
      fifo_data[wr_ptr] <= avs_slave_writedata;
    end
  end

  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign pix_a     = head_data[31:16];
  assign pix_b     = head_data[15:0];

  palette_match u_match_a (
    .palette (palette_q),
    .pixel   (pix_a),
    .index   (idx_a),
    .miss    (miss_a)
  );

  palette_match u_match_b (
    .palette (palette_q),
    .pixel   (pix_b),
    .index   (idx_b),
    .miss    (miss_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      miss_q    <= 1'b0;
    end else begin
      if (pop) begin
        out_valid <= 1'b1;
        out_addr  <= head_addr;
        out_data  <= {idx_a, idx_b};
        if (miss_a || miss_b) miss_q <= 1'b1;
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Unlike the FIFO, the palette is reset: its reset contents are visible
  // behaviour, not scratch storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      palette_q  <= DEFAULT_PALETTE;
      readdata_q <= '0;
    end else begin
      if (avs_palette_write) palette_q[avs_palette_address] <= avs_palette_writedata;
      readdata_q <= palette_q[avs_palette_address];
    end
  end

  assign avs_slave_waitrequest = full_q;
  assign avm_master_write      = out_valid;
  assign avm_master_address    = out_addr;
  assign avm_master_writedata  = out_data;
  assign avs_palette_readdata  = readdata_q;
  assign lookup_miss           = miss_q;

endmodule

// File: tb/tb_palette_packer.sv
// tb_palette_packer: directed stimulus with a queue scoreboard; a monitor pops
// an expected {address, byte} on every completed master write.
module tb_palette_packer;

  localparam int ADDR_W = 24;

  logic              clk;
  logic              reset;
  logic              avs_slave_write;
  logic [ADDR_W-1:0] avs_slave_address;
  logic [31:0]       avs_slave_writedata;
  logic              avs_slave_waitrequest;
  logic              avm_master_write;
  logic [ADDR_W-1:0] avm_master_address;
  logic [7:0]        avm_master_writedata;
  logic              avm_master_waitrequest;
  logic [3:0]        avs_palette_address;
  logic [15:0]       avs_palette_writedata;
  logic              avs_palette_write;
  logic [15:0]       avs_palette_readdata;
  logic              lookup_miss;

  palette_packer #(.FIFO_DEPTH(4), .ADDR_W(ADDR_W)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .avs_slave_write        (avs_slave_write),
    .avs_slave_address      (avs_slave_address),
    .avs_slave_writedata    (avs_slave_writedata),
    .avs_slave_waitrequest  (avs_slave_waitrequest),
    .avm_master_write       (avm_master_write),
    .avm_master_address     (avm_master_address),
    .avm_master_writedata   (avm_master_writedata),
    .avm_master_waitrequest (avm_master_waitrequest),
    .avs_palette_address    (avs_palette_address),
    .avs_palette_writedata  (avs_palette_writedata),
    .avs_palette_write      (avs_palette_write),
    .avs_palette_readdata   (avs_palette_readdata),
    .lookup_miss            (lookup_miss)
  );

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Monitor: a transfer completes at the edge after a cycle with write=1 and
  // waitrequest=0; sample mid-cycle, clear of both edges.
  always begin
    logic nonempty;
    @(negedge clk);
    #1;
    if (!reset && avm_master_write && !avm_master_waitrequest) begin
      nonempty = (exp_q.size() != 0);
      check("sb_has_entry", 32'(nonempty), 32'd1);
      if (nonempty) check("master_write", {avm_master_address, avm_master_writedata}, exp_q.pop_front());
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic slave_write(input logic [23:0] a, input logic [31:0] d, input logic [7:0] exp);
    int waited = 0;
    avs_slave_write     = 1'b1;
    avs_slave_address   = a;
    avs_slave_writedata = d;
    while (avs_slave_waitrequest && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (avs_slave_waitrequest) begin
      check("slave_accept_timeout", 32'(avs_slave_waitrequest), 32'd0);
      avs_slave_write = 1'b0;
      return;
    end
    exp_q.push_back({a, exp});
    @(negedge clk);
    avs_slave_write = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pal_read(input string name, input logic [3:0] a, input logic [15:0] exp);
    avs_palette_address = a;
    @(negedge clk);
    check(name, 32'(avs_palette_readdata), 32'(exp));
  endtask

  initial begin
    reset                  = 1'b1;
    avs_slave_write        = 1'b0;
    avs_slave_address      = '0;
    avs_slave_writedata    = '0;
    avm_master_waitrequest = 1'b0;
    avs_palette_address    = '0;
    avs_palette_writedata  = '0;
    avs_palette_write      = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_master_write", 32'(avm_master_write), 32'd0);
    check("rst_master_addr",  32'(avm_master_address), 32'd0);
    check("rst_master_data",  32'(avm_master_writedata), 32'd0);
    check("rst_slave_wait",   32'(avs_slave_waitrequest), 32'd0);
    check("rst_pal_readdata", 32'(avs_palette_readdata), 32'd0);
    check("rst_lookup_miss",  32'(lookup_miss), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // White/red pair: one byte write exactly two edges after acceptance.
    slave_write(24'h000010, 32'hFFFF_F800, 8'h12);
    check("lat_edge_n1_idle", 32'(avm_master_write), 32'd0);
    @(negedge clk);
    check("lat_edge_n2_write", 32'(avm_master_write), 32'd1);
    @(negedge clk);
    check("lat_single_write", 32'(avm_master_write), 32'd0);
    wait_drain("drain_basic");

    // Palette write: same-cycle readdata is the old entry, then the new one.
    avs_palette_address   = 4'd9;
    avs_palette_writedata = 16'h1234;
    avs_palette_write     = 1'b1;
    @(negedge clk);
    avs_palette_write = 1'b0;
    check("pal_write_old", 32'(avs_palette_readdata), 32'h0000_FFFF);
    @(negedge clk);
    check("pal_write_new", 32'(avs_palette_readdata), 32'h0000_1234);
    slave_write(24'h000020, 32'h1234_0000, 8'h90);
    wait_drain("drain_pal9");
    check("miss_clear_exact", 32'(lookup_miss), 32'd0);

    // Unmatched 0x0841 maps to black in both build modes; green matches.
    slave_write(24'h000030, 32'h0841_07E0, 8'h03);
    wait_drain("drain_miss");
    check("miss_set", 32'(lookup_miss), 32'd1);
    slave_write(24'h000031, 32'h001F_FFFF, 8'h41);
    wait_drain("drain_sticky");
    check("miss_sticky", 32'(lookup_miss), 32'd1);

    // Backpressure: 4 held in the FIFO plus 1 in the lookup register.
    avm_master_waitrequest = 1'b1;
    slave_write(24'h000100, 32'h0000_FFFF, 8'h01);
    slave_write(24'h000101, 32'hF800_07E0, 8'h23);
    slave_write(24'h000102, 32'h001F_07FF, 8'h45);
    slave_write(24'h000103, 32'hF81F_FFE0, 8'h67);
    check("wait_low_at_4", 32'(avs_slave_waitrequest), 32'd0);
    slave_write(24'h000104, 32'h07E0_0000, 8'h30);
    check("wait_high_at_5", 32'(avs_slave_waitrequest), 32'd1);
    repeat (3) @(negedge clk);
    check("wait_held", 32'(avs_slave_waitrequest), 32'd1);
    check("stall_addr_held", 32'(avm_master_address), 32'h0000_0100);
    avm_master_waitrequest = 1'b0;
    @(negedge clk);
    check("wait_drops", 32'(avs_slave_waitrequest), 32'd0);
    slave_write(24'h000105, 32'hFFE0_F800, 8'h72);
    wait_drain("drain_backpressure");

    // Reset during a stalled master write abandons it for good.
    avm_master_waitrequest = 1'b1;
    slave_write(24'h0000AA, 32'hFFFF_FFFF, 8'h11);
    @(negedge clk);
    check("stalled_write_up", 32'(avm_master_write), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("reset_abandons", 32'(avm_master_write), 32'd0);
    check("reset_addr", 32'(avm_master_address), 32'd0);
    check("reset_miss", 32'(lookup_miss), 32'd0);
    reset = 1'b0;
    avm_master_waitrequest = 1'b0;
    repeat (5) @(negedge clk);
    check("no_reissue", 32'(avm_master_write), 32'd0);
    pal_read("pal_rst_entry2", 4'd2, 16'hF800);
    pal_read("pal_rst_entry9", 4'd9, 16'hFFFF);
    pal_read("pal_rst_entry15", 4'd15, 16'hFFE0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
